reg_write_arbiter: RTL and testbench

- Shares the register file's single write port between two writeback requesters:
  - A: ALU writeback.
  - B: load/memory writeback.
- Each requester has a DEPTH-entry FIFO. A round-robin arbiter drains at most one entry per cycle into a registered write stage. That stage drives the register file's WriteEnable/WriteRegister/WriteData inputs directly.
- A combinational pending-query port lets hazard logic stall readers of registers that still have queued writes.
- Writes to register 0 are consumed but never issued, so register 0 stays zero.

---
 rtl/reg_write_arbiter.sv | 109 ++++++++++
 tb/tb_reg_write_arbiter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: shares one register-file write port between two FIFO-buffered writeback requesters
// Ports:
//   clk, reset                       clock, asynchronous active-high reset
//   ValidA/ReadyA/RegisterA/DataA    ALU writeback request and its backpressure
//   ValidB/ReadyB/RegisterB/DataB    load/memory writeback request and its backpressure
//   WriteEnable/WriteRegister/WriteData  registered write stage feeding the register file
//   QueryRegister/QueryPending       combinational probe for queued or in-flight writes
//   Idle                             both FIFOs empty and no write in the write stage
module reg_write_arbiter #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ValidA,
    output logic        ReadyA,
    input  logic [4:0]  RegisterA,
    input  logic [31:0] DataA,
    input  logic        ValidB,
    output logic        ReadyB,
    input  logic [4:0]  RegisterB,
    input  logic [31:0] DataB,
    output logic        WriteEnable,
    output logic [4:0]  WriteRegister,
    output logic [31:0] WriteData,
    input  logic [4:0]  QueryRegister,
    output logic        QueryPending,
    output logic        Idle
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [4:0]    r_reg_a [DEPTH];
    logic [31:0]   r_dat_a [DEPTH];
    logic [4:0]    r_reg_b [DEPTH];
    logic [31:0]   r_dat_b [DEPTH];
    logic [AW-1:0] r_wp_a, r_rp_a, r_wp_b, r_rp_b;
    logic [CW-1:0] r_cnt_a, r_cnt_b;
    logic          r_last_b;

    logic          w_push_a, w_push_b, w_ne_a, w_ne_b, w_grant_a, w_grant_b, w_hit;
    logic [4:0]    w_head_reg;
    logic [31:0]   w_head_dat;

    assign ReadyA     = r_cnt_a < CW'(DEPTH);
    assign ReadyB     = r_cnt_b < CW'(DEPTH);
    assign w_push_a   = ValidA && ReadyA;
    assign w_push_b   = ValidB && ReadyB;
    assign w_ne_a     = r_cnt_a != '0;
    assign w_ne_b     = r_cnt_b != '0;
    // On contention the side that did not win last time gets the slot
    assign w_grant_a  = w_ne_a && (!w_ne_b || r_last_b);
    assign w_grant_b  = w_ne_b && !w_grant_a;
    assign w_head_reg = w_grant_a ? r_reg_a[r_rp_a] : r_reg_b[r_rp_b];
    assign w_head_dat = w_grant_a ? r_dat_a[r_rp_a] : r_dat_b[r_rp_b];
    assign Idle       = !w_ne_a && !w_ne_b && !WriteEnable;

    // FIFO storage needs no reset: only slots within the live count are ever observed
    always_ff @(posedge clk) begin
        if (w_push_a) begin
            r_reg_a[r_wp_a] <= RegisterA;
            r_dat_a[r_wp_a] <= DataA;
        end
        if (w_push_b) begin
            r_reg_b[r_wp_b] <= RegisterB;
            r_dat_b[r_wp_b] <= DataB;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wp_a        <= '0;
            r_rp_a        <= '0;
            r_wp_b        <= '0;
            r_rp_b        <= '0;
            r_cnt_a       <= '0;
            r_cnt_b       <= '0;
            r_last_b      <= 1'b1;
            WriteEnable   <= 1'b0;
            WriteRegister <= '0;
            WriteData     <= '0;
        end else begin
            if (w_push_a) r_wp_a <= r_wp_a + 1'b1;
            if (w_push_b) r_wp_b <= r_wp_b + 1'b1;
            if (w_grant_a) r_rp_a <= r_rp_a + 1'b1;
            if (w_grant_b) r_rp_b <= r_rp_b + 1'b1;
            r_cnt_a <= r_cnt_a + CW'(w_push_a) - CW'(w_grant_a);
            r_cnt_b <= r_cnt_b + CW'(w_push_b) - CW'(w_grant_b);
            if (w_ne_a && w_ne_b) r_last_b <= w_grant_b;
            if (w_grant_a || w_grant_b) begin
                WriteRegister <= w_head_reg;
                WriteData     <= w_head_dat;
                // Register-0 entries still consume the slot but never assert the write
                WriteEnable   <= w_head_reg != 5'd0;
            end else begin
                WriteEnable   <= 1'b0;
            end
        end
    end

    // An entry is live when its distance from the read pointer is below the count
    always_comb begin
        w_hit = WriteEnable && (WriteRegister == QueryRegister);
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(AW'(i) - r_rp_a) < r_cnt_a && r_reg_a[i] == QueryRegister) w_hit = 1'b1;
            if (CW'(AW'(i) - r_rp_b) < r_cnt_b && r_reg_b[i] == QueryRegister) w_hit = 1'b1;
        end
        QueryPending = w_hit && (QueryRegister != 5'd0);
    end
endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb_reg_write_arbiter: directed scenario bench for reg_write_arbiter
module tb_reg_write_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ValidA = 1'b0, ValidB = 1'b0;
    logic        ReadyA, ReadyB;
    logic [4:0]  RegisterA = '0, RegisterB = '0, QueryRegister = '0;
    logic [31:0] DataA = '0, DataB = '0;
    logic        WriteEnable, QueryPending, Idle;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData;
    int          vectors = 0;
    int          miscompares = 0;

    reg_write_arbiter #(.DEPTH(2)) dut (
        .clk(clk), .reset(reset),
        .ValidA(ValidA), .ReadyA(ReadyA), .RegisterA(RegisterA), .DataA(DataA),
        .ValidB(ValidB), .ReadyB(ReadyB), .RegisterB(RegisterB), .DataB(DataB),
        .WriteEnable(WriteEnable), .WriteRegister(WriteRegister), .WriteData(WriteData),
        .QueryRegister(QueryRegister), .QueryPending(QueryPending), .Idle(Idle)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        vectors++; if (WriteEnable !== 1'b0) begin miscompares++; $display("FAIL reset_we got %b want 0", WriteEnable); end
        vectors++; if (WriteRegister !== 5'd0) begin miscompares++; $display("FAIL reset_wr got %0d want 0", WriteRegister); end
        vectors++; if (WriteData !== 32'd0) begin miscompares++; $display("FAIL reset_wd got %h want 0", WriteData); end
        vectors++; if (ReadyA !== 1'b1 || ReadyB !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %b%b want 11", ReadyA, ReadyB); end
        vectors++; if (Idle !== 1'b1) begin miscompares++; $display("FAIL reset_idle got %b want 1", Idle); end
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_single();
        ValidA = 1'b1; RegisterA = 5'd5; DataA = 32'hDEADBEEF;
        step();
        ValidA = 1'b0;
        vectors++; if (WriteEnable !== 1'b0) begin miscompares++; $display("FAIL single_we_n got %b want 0", WriteEnable); end
        vectors++; if (Idle !== 1'b0) begin miscompares++; $display("FAIL single_idle_n got %b want 0", Idle); end
        step();
        vectors++; if (WriteEnable !== 1'b1) begin miscompares++; $display("FAIL single_we got %b want 1", WriteEnable); end
        vectors++; if (WriteRegister !== 5'd5) begin miscompares++; $display("FAIL single_wr got %0d want 5", WriteRegister); end
        vectors++; if (WriteData !== 32'hDEADBEEF) begin miscompares++; $display("FAIL single_wd got %h want deadbeef", WriteData); end
        step();
        vectors++; if (WriteEnable !== 1'b0) begin miscompares++; $display("FAIL single_we_off got %b want 0", WriteEnable); end
        vectors++; if (Idle !== 1'b1) begin miscompares++; $display("FAIL single_idle got %b want 1", Idle); end
    endtask

    task automatic test_contention();
        logic [4:0] exp_seq [4] = '{5'd1, 5'd3, 5'd2, 5'd4};
        ValidA = 1'b1; RegisterA = 5'd1; DataA = 32'h11;
        ValidB = 1'b1; RegisterB = 5'd3; DataB = 32'h33;
        step();
        RegisterA = 5'd2; DataA = 32'h22;
        RegisterB = 5'd4; DataB = 32'h44;
        step();
        ValidA = 1'b0; ValidB = 1'b0;
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (WriteEnable !== 1'b1 || WriteRegister !== exp_seq[k]) begin
                miscompares++; $display("FAIL contention_%0d got we=%b r%0d want we=1 r%0d", k, WriteEnable, WriteRegister, exp_seq[k]);
            end
            if (k < 3) step();
        end
        step();
        vectors++; if (WriteEnable !== 1'b0 || Idle !== 1'b1) begin miscompares++; $display("FAIL contention_end got we=%b idle=%b want 0 1", WriteEnable, Idle); end
    endtask

    task automatic test_backpressure();
        int  sa = 0, sb = 0, ra = 0, rb = 0;
        bit  fa, fb, lowb = 0;
        for (int c = 0; c < 40; c++) begin
            ValidA = sa < 10; RegisterA = 5'(20 + sa); DataA = 32'(100 + sa);
            ValidB = sb < 10; RegisterB = 5'(8 + sb);  DataB = 32'(1 + sb);
            fa = ValidA && ReadyA;
            fb = ValidB && ReadyB;
            if (!ReadyB) lowb = 1;
            step();
            if (fa) sa++;
            if (fb) sb++;
            if (WriteEnable) begin
                if (WriteRegister >= 5'd20) begin
                    vectors++;
                    if (WriteRegister !== 5'(20 + ra) || WriteData !== 32'(100 + ra)) begin
                        miscompares++; $display("FAIL bp_a_%0d got r%0d %0d want r%0d %0d", ra, WriteRegister, WriteData, 20 + ra, 100 + ra);
                    end
                    ra++;
                end else begin
                    vectors++;
                    if (WriteRegister !== 5'(8 + rb) || WriteData !== 32'(1 + rb)) begin
                        miscompares++; $display("FAIL bp_b_%0d got r%0d %0d want r%0d %0d", rb, WriteRegister, WriteData, 8 + rb, 1 + rb);
                    end
                    rb++;
                end
            end
        end
        ValidA = 1'b0; ValidB = 1'b0;
        vectors++; if (ra != 10 || rb != 10) begin miscompares++; $display("FAIL bp_count got a=%0d b=%0d want 10 10", ra, rb); end
        vectors++; if (lowb != 1) begin miscompares++; $display("FAIL bp_readyb_low got %0d want 1", lowb); end
        vectors++; if (Idle !== 1'b1) begin miscompares++; $display("FAIL bp_idle got %b want 1", Idle); end
    endtask

    task automatic test_reg0();
        QueryRegister = 5'd0;
        ValidA = 1'b1; RegisterA = 5'd0; DataA = 32'hFFFFFFFF;
        step();
        ValidA = 1'b0;
        vectors++; if (QueryPending !== 1'b0) begin miscompares++; $display("FAIL reg0_qp_q got %b want 0", QueryPending); end
        vectors++; if (Idle !== 1'b0) begin miscompares++; $display("FAIL reg0_idle_n got %b want 0", Idle); end
        step();
        vectors++; if (WriteEnable !== 1'b0) begin miscompares++; $display("FAIL reg0_we got %b want 0", WriteEnable); end
        vectors++; if (WriteData !== 32'hFFFFFFFF || WriteRegister !== 5'd0) begin miscompares++; $display("FAIL reg0_pop got r%0d %h want r0 ffffffff", WriteRegister, WriteData); end
        vectors++; if (Idle !== 1'b1 || QueryPending !== 1'b0) begin miscompares++; $display("FAIL reg0_done got idle=%b qp=%b want 1 0", Idle, QueryPending); end
    endtask

    task automatic test_pending();
        QueryRegister = 5'd7;
        #1;
        vectors++; if (QueryPending !== 1'b0) begin miscompares++; $display("FAIL pend_pre got %b want 0", QueryPending); end
        ValidA = 1'b1; RegisterA = 5'd7; DataA = 32'h77;
        step();
        ValidA = 1'b0;
        vectors++; if (QueryPending !== 1'b1) begin miscompares++; $display("FAIL pend_fifo got %b want 1", QueryPending); end
        QueryRegister = 5'd8;
        #1;
        vectors++; if (QueryPending !== 1'b0) begin miscompares++; $display("FAIL pend_other got %b want 0", QueryPending); end
        QueryRegister = 5'd7;
        step();
        vectors++; if (QueryPending !== 1'b1 || WriteEnable !== 1'b1) begin miscompares++; $display("FAIL pend_stage got qp=%b we=%b want 1 1", QueryPending, WriteEnable); end
        step();
        vectors++; if (QueryPending !== 1'b0 || WriteEnable !== 1'b0) begin miscompares++; $display("FAIL pend_clear got qp=%b we=%b want 0 0", QueryPending, WriteEnable); end
    endtask

    task automatic test_async_reset();
        ValidA = 1'b1; RegisterA = 5'd1; DataA = 32'h11;
        ValidB = 1'b1; RegisterB = 5'd2; DataB = 32'h22;
        step();
        RegisterA = 5'd3; RegisterB = 5'd4;
        step();
        ValidA = 1'b0; ValidB = 1'b0;
        vectors++; if (WriteEnable !== 1'b1) begin miscompares++; $display("FAIL ar_pre_we got %b want 1", WriteEnable); end
        #3;
        reset = 1'b1;
        #1;
        vectors++; if (WriteEnable !== 1'b0 || WriteRegister !== 5'd0 || WriteData !== 32'd0) begin miscompares++; $display("FAIL ar_outputs got we=%b r%0d %h want 0 r0 0", WriteEnable, WriteRegister, WriteData); end
        vectors++; if (Idle !== 1'b1 || ReadyA !== 1'b1 || ReadyB !== 1'b1) begin miscompares++; $display("FAIL ar_state got idle=%b ready=%b%b want 1 11", Idle, ReadyA, ReadyB); end
        #2;
        reset = 1'b0;
        step();
        vectors++; if (WriteEnable !== 1'b0) begin miscompares++; $display("FAIL ar_stale1 got %b want 0", WriteEnable); end
        step();
        vectors++; if (WriteEnable !== 1'b0 || Idle !== 1'b1) begin miscompares++; $display("FAIL ar_stale2 got we=%b idle=%b want 0 1", WriteEnable, Idle); end
        ValidA = 1'b1; RegisterA = 5'd10; DataA = 32'hA;
        ValidB = 1'b1; RegisterB = 5'd11; DataB = 32'hB;
        step();
        ValidA = 1'b0; ValidB = 1'b0;
        step();
        vectors++; if (WriteEnable !== 1'b1 || WriteRegister !== 5'd10) begin miscompares++; $display("FAIL ar_first got we=%b r%0d want 1 r10", WriteEnable, WriteRegister); end
        step();
        vectors++; if (WriteEnable !== 1'b1 || WriteRegister !== 5'd11) begin miscompares++; $display("FAIL ar_second got we=%b r%0d want 1 r11", WriteEnable, WriteRegister); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_reg0();
        test_pending();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
